// File: rtl/unidade_controle.sv
// Fetch/decode/execute sequencer feeding the ULA: holds a 16x8 program/data RAM,
// steps through it three cycles per instruction and drives the ULA bus/enables.
module unidade_controle #(
    parameter int unsigned LARGURA_DADOS = 8,
    parameter int unsigned LARGURA_END   = 4
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Iniciar,
    input  logic                     ProgEnable,
    input  logic [LARGURA_END-1:0]   ProgEndereco,
    input  logic [LARGURA_DADOS-1:0] ProgDado,
    input  logic                     Zero,
    output logic [LARGURA_DADOS-1:0] barramentoDados,
    output logic                     RegEnable,
    output logic [2:0]               UlaOp,
    output logic                     SaidaEnable,
    output logic [LARGURA_END-1:0]   PC,
    output logic [2:0]               Estado,
    output logic                     Parado
);

    localparam int unsigned PROFUNDIDADE = 2 ** LARGURA_END;

    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } estado_t;

    estado_t                  estado;
    logic [LARGURA_DADOS-1:0] IR;
    logic [LARGURA_DADOS-1:0] mem [PROFUNDIDADE];
    logic [3:0]               opcode;
    logic [LARGURA_END-1:0]   endA;
    logic                     parado;

    assign opcode = IR[LARGURA_DADOS-1 -: 4];
    assign endA   = IR[LARGURA_END-1:0];
    assign Estado = estado;
    assign parado = (estado == IDLE) || (estado == HALT);

    // Program loading is only possible while the sequencer is stopped.
    always_ff @(posedge Clock) begin
        if (ProgEnable && parado) begin
            mem[ProgEndereco] <= ProgDado;
        end
    end

    // Sequencer; ULA controls are set entering EXECUTE and cleared leaving it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            estado          <= IDLE;
            PC              <= '0;
            IR              <= '0;
            barramentoDados <= '0;
            RegEnable       <= 1'b0;
            UlaOp           <= '0;
            SaidaEnable     <= 1'b0;
            Parado          <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (Iniciar) begin
                        estado <= FETCH;
                        PC     <= '0;
                    end
                end
                FETCH: begin
                    IR     <= mem[PC];
                    estado <= DECODE;
                end
                DECODE: begin
                    if (opcode == OP_HALT) begin
                        estado <= HALT;
                        Parado <= 1'b1;
                    end else begin
                        estado <= EXECUTE;
                        case (opcode)
                            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                                RegEnable       <= 1'b1;
                                UlaOp           <= 3'(opcode - 4'd1);
                                barramentoDados <= mem[endA];
                            end
                            OP_OUT: begin
                                SaidaEnable <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                EXECUTE: begin
                    RegEnable   <= 1'b0;
                    SaidaEnable <= 1'b0;
                    UlaOp       <= '0;
                    estado      <= FETCH;
                    if ((opcode == OP_JMP) || ((opcode == OP_JZ) && Zero)) begin
                        PC <= endA;
                    end else begin
                        PC <= PC + LARGURA_END'(1);
                    end
                end
                HALT: begin
                    if (Iniciar) begin
                        estado <= FETCH;
                        PC     <= '0;
                        Parado <= 1'b0;
                    end
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: an instruction-level model fills a per-cycle
// expectation queue that is popped and compared on every falling edge.
module tb_unidade_controle;

    logic       Clock;
    logic       Resetn;
    logic       Iniciar;
    logic       ProgEnable;
    logic [3:0] ProgEndereco;
    logic [7:0] ProgDado;
    logic       Zero;
    logic [7:0] barramentoDados;
    logic       RegEnable;
    logic [2:0] UlaOp;
    logic       SaidaEnable;
    logic [3:0] PC;
    logic [2:0] Estado;
    logic       Parado;

    unidade_controle #(.LARGURA_DADOS(8), .LARGURA_END(4)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .Iniciar(Iniciar),
        .ProgEnable(ProgEnable),
        .ProgEndereco(ProgEndereco),
        .ProgDado(ProgDado),
        .Zero(Zero),
        .barramentoDados(barramentoDados),
        .RegEnable(RegEnable),
        .UlaOp(UlaOp),
        .SaidaEnable(SaidaEnable),
        .PC(PC),
        .Estado(Estado),
        .Parado(Parado)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       regEn;
        logic [2:0] op;
        logic [7:0] bus;
        logic       saida;
        logic [3:0] pc;
        logic [2:0] est;
        logic       par;
    } rec_t;

    rec_t       sbq[$];
    logic [7:0] tbMem [16];
    logic [7:0] img [16];
    logic [3:0] mPc;
    logic [7:0] mBus;
    int         checks;
    int         errors;

    function automatic rec_t mk(input logic re, input logic [2:0] op, input logic [7:0] bus,
                                input logic so, input logic [3:0] pc, input logic [2:0] est,
                                input logic par);
        rec_t r;
        r.regEn = re;
        r.op    = op;
        r.bus   = bus;
        r.saida = so;
        r.pc    = pc;
        r.est   = est;
        r.par   = par;
        return r;
    endfunction

    // Instruction-level reference: three records per instruction, HALT repeats.
    task automatic buildExpect(input int n);
        logic [7:0] ir;
        logic [3:0] opc;
        logic [3:0] a;
        rec_t       r;
        while (sbq.size() < n) begin
            ir  = tbMem[mPc];
            opc = ir[7:4];
            a   = ir[3:0];
            sbq.push_back(mk(1'b0, 3'd0, mBus, 1'b0, mPc, 3'd1, 1'b0));
            sbq.push_back(mk(1'b0, 3'd0, mBus, 1'b0, mPc, 3'd2, 1'b0));
            if (opc == 4'hF) begin
                while (sbq.size() < n) sbq.push_back(mk(1'b0, 3'd0, mBus, 1'b0, mPc, 3'd4, 1'b1));
            end else begin
                r = mk(1'b0, 3'd0, mBus, 1'b0, mPc, 3'd3, 1'b0);
                if (opc >= 4'h1 && opc <= 4'h5) begin
                    mBus = tbMem[a];
                    r    = mk(1'b1, 3'(opc - 4'd1), mBus, 1'b0, mPc, 3'd3, 1'b0);
                end else if (opc == 4'h6) begin
                    r.saida = 1'b1;
                end
                sbq.push_back(r);
                if (opc == 4'h7 || (opc == 4'h8 && Zero)) mPc = a;
                else mPc = mPc + 4'd1;
            end
        end
    endtask

    task automatic runCycles(input string name, input int n, input int peCycles,
                             input logic [3:0] peAddr, input logic [7:0] peData);
        rec_t exp;
        rec_t act;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            Iniciar      = 1'b0;
            ProgEnable   = (i < peCycles);
            ProgEndereco = peAddr;
            ProgDado     = peData;
            exp = sbq.pop_front();
            act = mk(RegEnable, UlaOp, barramentoDados, SaidaEnable, PC, Estado, Parado);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cyc %0d: got re=%0b op=%0d bus=%02h out=%0b pc=%0d est=%0d par=%0b, expected re=%0b op=%0d bus=%02h out=%0b pc=%0d est=%0d par=%0b",
                         name, i + 1, act.regEn, act.op, act.bus, act.saida, act.pc, act.est, act.par,
                         exp.regEn, exp.op, exp.bus, exp.saida, exp.pc, exp.est, exp.par);
            end
        end
        ProgEnable = 1'b0;
        sbq.delete();
    endtask

    task automatic progWrite(input logic [3:0] addr, input logic [7:0] data);
        @(negedge Clock);
        ProgEnable   = 1'b1;
        ProgEndereco = addr;
        ProgDado     = data;
        tbMem[addr]  = data;
        @(negedge Clock);
        ProgEnable   = 1'b0;
    endtask

    task automatic loadImg();
        for (int i = 0; i < 16; i++) progWrite(4'(i), img[i]);
    endtask

    task automatic clearImg();
        for (int i = 0; i < 16; i++) img[i] = 8'h00;
    endtask

    task automatic startPulse(input logic pe, input logic [3:0] addr, input logic [7:0] data);
        @(negedge Clock);
        Iniciar      = 1'b1;
        ProgEnable   = pe;
        ProgEndereco = addr;
        ProgDado     = data;
        if (pe) tbMem[addr] = data;
        mPc = 4'd0;
    endtask

    task automatic doReset();
        @(negedge Clock);
        Resetn = 1'b0;
        mBus   = 8'h00;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic checkVal(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rec_t act;
        Resetn = 1'b0; Iniciar = 1'b0; ProgEnable = 1'b0;
        ProgEndereco = 4'd0; ProgDado = 8'h00; Zero = 1'b0;
        mBus = 8'h00; mPc = 4'd0;
        #12;
        act = mk(RegEnable, UlaOp, barramentoDados, SaidaEnable, PC, Estado, Parado);
        checks++;
        if (act !== mk(1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL reset: got %0h expected all-zero outputs", act);
        end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_wrap();
        clearImg();
        loadImg();
        startPulse(1'b0, 4'd0, 8'h00);
        buildExpect(51);
        runCycles("wrap", 51, 0, 4'd0, 8'h00);
        checkVal("wrap_pc", 8'(PC), 8'h00);
        checkVal("wrap_not_halted", 8'(Parado), 8'h00);
        doReset();
    endtask

    task automatic test_jumps();
        logic [7:0] inst [3];
        logic       zv   [3];
        logic [3:0] pcv  [3];
        inst[0] = 8'h83; zv[0] = 1'b1; pcv[0] = 4'd3;
        inst[1] = 8'h83; zv[1] = 1'b0; pcv[1] = 4'd1;
        inst[2] = 8'h7F; zv[2] = 1'b0; pcv[2] = 4'd15;
        for (int k = 0; k < 3; k++) begin
            progWrite(4'd0, inst[k]);
            Zero = zv[k];
            startPulse(1'b0, 4'd0, 8'h00);
            buildExpect(4);
            runCycles("jump", 4, 0, 4'd0, 8'h00);
            checkVal("jump_pc", 8'(PC), 8'(pcv[k]));
            doReset();
        end
        Zero = 1'b0;
    endtask

    task automatic loadProgram();
        clearImg();
        img[0] = 8'h1A; img[1] = 8'h2B; img[2] = 8'h60; img[3] = 8'hF0;
        img[10] = 8'h05; img[11] = 8'h03;
        loadImg();
    endtask

    task automatic test_program();
        loadProgram();
        startPulse(1'b0, 4'd0, 8'h00);
        buildExpect(14);
        runCycles("program", 14, 0, 4'd0, 8'h00);
        checkVal("prog_pc", 8'(PC), 8'h03);
        checkVal("prog_estado", 8'(Estado), 8'h04);
        checkVal("prog_parado", 8'(Parado), 8'h01);
        checkVal("prog_bus", barramentoDados, 8'h03);
    endtask

    task automatic test_write_blocked();
        clearImg();
        img[1] = 8'h15; img[2] = 8'hF0; img[5] = 8'h11;
        loadImg();
        startPulse(1'b0, 4'd0, 8'h00);
        buildExpect(9);
        runCycles("wr_blocked", 9, 3, 4'd5, 8'hAA);
        checkVal("wr_blocked_bus", barramentoDados, 8'h11);
    endtask

    task automatic test_reset_mid();
        rec_t act;
        loadProgram();
        startPulse(1'b0, 4'd0, 8'h00);
        buildExpect(3);
        runCycles("pre_reset", 3, 0, 4'd0, 8'h00);
        #1 Resetn = 1'b0;
        #1;
        act = mk(RegEnable, UlaOp, barramentoDados, SaidaEnable, PC, Estado, Parado);
        checks++;
        if (act !== mk(1'b0, 3'd0, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset: got %0h expected all-zero outputs", act);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        mBus   = 8'h00;
        startPulse(1'b0, 4'd0, 8'h00);
        buildExpect(14);
        runCycles("restart", 14, 0, 4'd0, 8'h00);
    endtask

    task automatic test_halt_restart();
        startPulse(1'b1, 4'd0, 8'hF0);
        buildExpect(5);
        runCycles("halt_restart", 5, 0, 4'd0, 8'h00);
        checkVal("halt_restart_parado", 8'(Parado), 8'h01);
        checkVal("halt_restart_pc", 8'(PC), 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap();
        test_jumps();
        test_program();
        test_write_blocked();
        test_reset_mid();
        test_halt_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
